// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the alu_wb_seq sequencer.
//   op_e    : 3-bit operation code (ADD..MUL)
//   state_e : sequencer FSM states
//   RA_W    : register-bank address width
package alu_wb_pkg;

    localparam int RA_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_wb_alu.sv
// Combinational ALU for the single-cycle ops (ADD..SRL).
//   op : operation code
//   a  : operand 1 (rs1)
//   b  : operand 2 (rs2); its low $clog2(W) bits are the shift amount
//   y  : result, modulo 2^W; MUL is not handled here and yields 0
module alu_wb_alu
    import alu_wb_pkg::*;
#(
    parameter int W = 16
) (
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam int SH_W = $clog2(W);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_wb_seq.sv
// Read / execute / write-back sequencer in front of an external register bank.
// One instruction at a time: IDLE -> READ -> EXEC -> WB -> IDLE.
//   clk, rst            : clock, synchronous active-high reset
//   instr_valid/_ready  : instruction handshake (ready only in IDLE)
//   op, rd, rs1, rs2    : instruction fields, latched on handshake
//   addr_rs1, addr_rs2  : bank read addresses; rs1_data/rs2_data come back
//                         combinationally and are captured at the end of READ
//   addr_rd, data_in, WE: bank write port, active in WB
//   done, err           : one-cycle completion pulse; err flags an illegal op
// Build option: ALU_WB_MUL_EN enables op 7 as a W-cycle shift-add multiply;
// without it op 7 completes with err=1 and no write.
module alu_wb_seq
    import alu_wb_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      op,
    input  logic [RA_W-1:0] rd,
    input  logic [RA_W-1:0] rs1,
    input  logic [RA_W-1:0] rs2,
    output logic [RA_W-1:0] addr_rs1,
    output logic [RA_W-1:0] addr_rs2,
    input  logic [W-1:0]    rs1_data,
    input  logic [W-1:0]    rs2_data,
    output logic [RA_W-1:0] addr_rd,
    output logic [W-1:0]    data_in,
    output logic            WE,
    output logic            done,
    output logic            err
);

    state_e          state, nxt;
    op_e             op_q;
    logic [RA_W-1:0] rd_q, rs1_q, rs2_q;
    logic [W-1:0]    a_q, b_q, res_q;
    logic [W-1:0]    alu_y;
    logic            exec_last;
    logic            illegal;
    logic            rd_ok;

    alu_wb_alu #(.W(W)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y)
    );

`ifdef ALU_WB_MUL_EN
    localparam int CW = $clog2(W);
    logic [CW-1:0] cnt;

    // Iteration counter, cleared whenever we are not executing.
    always_ff @(posedge clk) begin
        if (rst || state != S_EXEC) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

    assign exec_last = (op_q != OP_MUL) || (cnt == CW'(W - 1));
    assign illegal   = 1'b0;
`else
    assign exec_last = 1'b1;
    assign illegal   = (op_q == OP_MUL);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (instr_valid) nxt = S_READ;
            S_READ:  nxt = S_EXEC;
            S_EXEC:  if (exec_last) nxt = S_WB;
            S_WB:    nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_ADD;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (instr_valid) begin
                    op_q  <= op_e'(op);
                    rd_q  <= rd;
                    rs1_q <= rs1;
                    rs2_q <= rs2;
                end
                S_READ: begin
                    a_q   <= rs1_data;
                    b_q   <= rs2_data;
                    res_q <= '0;       // multiply accumulator starts from zero
                end
                S_EXEC: begin
`ifdef ALU_WB_MUL_EN
                    if (op_q == OP_MUL) begin
                        // a_q walks the multiplicand left, b_q the multiplier right.
                        if (b_q[0]) res_q <= res_q + a_q;
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end else begin
                        res_q <= alu_y;
                    end
`else
                    res_q <= alu_y;
`endif
                end
                default: ;
            endcase
        end
    end

    // Writes to r0 or to addresses beyond the bank size are dropped.
    assign rd_ok = (rd_q != '0) && ({1'b0, rd_q} < (RA_W + 1)'(N));

    // Gating with rst keeps an aborted WB from writing at the reset edge.
    assign instr_ready = (state == S_IDLE) && !rst;
    assign done        = (state == S_WB) && !rst;
    assign err         = done && illegal;
    assign WE          = done && !illegal && rd_ok;

    assign addr_rs1 = rs1_q;
    assign addr_rs2 = rs2_q;
    assign addr_rd  = rd_q;
    assign data_in  = res_q;

endmodule

// File: tb/tb_alu_wb_seq.sv
module tb_alu_wb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [4:0]  addr_rs1, addr_rs2, addr_rd;
    logic [15:0] rs1_data, rs2_data, data_in;
    logic        WE, done, err;

    logic [15:0] bank [32];

    int checks   = 0;
    int failures = 0;

    // results captured by exec()
    int          lat;
    logic        seen;
    logic        o_we, o_err, o_done_after, o_rdy_after;
    logic [15:0] o_data;
    logic [4:0]  o_rd;

    alu_wb_seq #(.W(16), .N(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .addr_rs1    (addr_rs1),
        .addr_rs2    (addr_rs2),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .addr_rd     (addr_rd),
        .data_in     (data_in),
        .WE          (WE),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // register bank model: combinational read, write on rising edge
    assign rs1_data = bank[addr_rs1];
    assign rs2_data = bank[addr_rs2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) bank[i] <= 16'h0000;
            bank[1]  <= 16'hFFFF;
            bank[2]  <= 16'h0002;
            bank[5]  <= 16'h5555;
            bank[7]  <= 16'h0000;
            bank[8]  <= 16'h0001;
            bank[9]  <= 16'h0001;
            bank[10] <= 16'h0013;
            bank[11] <= 16'h8000;
            bank[12] <= 16'h000F;
            bank[13] <= 16'h0102;
            bank[14] <= 16'h0103;
            bank[19] <= 16'h7777;
            bank[20] <= 16'h1234;
            bank[21] <= 16'h0011;
            bank[31] <= 16'hBEEF;
        end else if (WE) begin
            bank[addr_rd] <= data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction, then keep a junk instruction offered while busy
    // (it must be ignored). Wait for done with a bound.
    task automatic exec(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2);
        @(negedge clk);
        op = o; rd = d; rs1 = s1; rs2 = s2; instr_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; rd = 5'd31; rs1 = 5'd1; rs2 = 5'd2;
        chk("read_addr_rs1", addr_rs1, s1);
        chk("read_addr_rs2", addr_rs2, s2);
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                seen   = 1'b1;
                o_we   = WE;
                o_err  = err;
                o_data = data_in;
                o_rd   = addr_rd;
            end
        end
        instr_valid = 1'b0;
        chk("done_seen", seen, 1'b1);
        @(posedge clk); #1;
        o_done_after = done;
        o_rdy_after  = instr_ready;
    endtask

    task automatic chk_single(input string tag, input logic [4:0] d, input logic [15:0] exp,
                              input logic exp_we);
        chk({tag, "_lat"}, lat, 2);
        chk({tag, "_data"}, o_data, exp);
        chk({tag, "_we"}, o_we, exp_we);
        chk({tag, "_err"}, o_err, 1'b0);
        chk({tag, "_addr_rd"}, o_rd, d);
        chk({tag, "_done_once"}, o_done_after, 1'b0);
        chk({tag, "_ready_k4"}, o_rdy_after, 1'b1);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; instr_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", WE, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_data_in", data_in, 16'h0000);
        chk("rst_addr_rd", addr_rd, 5'd0);
        chk("rst_addr_rs1", addr_rs1, 5'd0);
        chk("rst_addr_rs2", addr_rs2, 5'd0);
        chk("rst_ready_low", instr_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", instr_ready, 1'b1);

        // ADD r3 = FFFF + 0002 -> 0001 (carry dropped)
        exec(3'd0, 5'd3, 5'd1, 5'd2);
        chk_single("add", 5'd3, 16'h0001, 1'b1);
        chk("add_bank_r3", bank[3], 16'h0001);

        // SUB r0 = 0000 - 0001 -> FFFF, no write to r0
        exec(3'd1, 5'd0, 5'd7, 5'd8);
        chk_single("sub", 5'd0, 16'hFFFF, 1'b0);
        chk("sub_bank_r0", bank[0], 16'h0000);

        // SLL 0001 << (0x13 & 0xF = 3) -> 0008
        exec(3'd5, 5'd4, 5'd9, 5'd10);
        chk_single("sll", 5'd4, 16'h0008, 1'b1);

        // SRL 8000 >> 15 -> 0001
        exec(3'd6, 5'd4, 5'd11, 5'd12);
        chk_single("srl", 5'd4, 16'h0001, 1'b1);

        exec(3'd2, 5'd15, 5'd20, 5'd21);
        chk_single("and", 5'd15, 16'h0010, 1'b1);
        exec(3'd3, 5'd16, 5'd20, 5'd21);
        chk_single("or", 5'd16, 16'h1235, 1'b1);

        // dependent back-to-back: r5 = r1+r2 = 0001, r6 = r5^r5, r17 = r5+r5
        exec(3'd0, 5'd5, 5'd1, 5'd2);
        chk_single("dep_add", 5'd5, 16'h0001, 1'b1);
        exec(3'd4, 5'd6, 5'd5, 5'd5);
        chk_single("dep_xor", 5'd6, 16'h0000, 1'b1);
        exec(3'd0, 5'd17, 5'd5, 5'd5);
        chk_single("dep_add2", 5'd17, 16'h0002, 1'b1);
        chk("junk_ignored_r31", bank[31], 16'hBEEF);

        // MUL 0102 * 0103 = 0x10506 -> 0506
        exec(3'd7, 5'd18, 5'd13, 5'd14);
`ifdef ALU_WB_MUL_EN
        chk("mul_lat", lat, 17);
        chk("mul_data", o_data, 16'h0506);
        chk("mul_we", o_we, 1'b1);
        chk("mul_err", o_err, 1'b0);
        chk("mul_bank_r18", bank[18], 16'h0506);
`else
        chk("mul_lat", lat, 2);
        chk("mul_err", o_err, 1'b1);
        chk("mul_we", o_we, 1'b0);
        chk("mul_bank_r18", bank[18], 16'h0000);
`endif
        chk("mul_done_once", o_done_after, 1'b0);

        // reset while ADD r19 is in EXEC: no write, no done
        @(negedge clk);
        op = 3'd0; rd = 5'd19; rs1 = 5'd1; rs2 = 5'd2; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;            // now in EXEC
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_we", WE, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_data_in", data_in, 16'h0000);
        chk("abort_addr_rs1", addr_rs1, 5'd0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (WE || done) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_bank_r19", bank[19], 16'h7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
